// File: rtl/mole_game_fsm.sv
// mole_game_fsm: whack-a-mole game controller for the displaymole renderer.
// Takes mole requests from the music sequencer and stomps from the floor pads,
// keeps score and lives, and drives the animation state code to displaymole.
// One shared 32-bit timer serves as the start-delay counter, the mole
// countdown, the sound hold timer and the popup watchdog.
// Optional feature macro: MOLE_SPEEDUP_EN (countdown shortens as score grows).
module mole_game_fsm #(
  parameter logic [2:0]  LIVES_INIT    = 3'd3,
  parameter int unsigned START_DELAY   = 65_000_000,
  parameter int unsigned MOLE_TIME     = 65_000_000,
  parameter int unsigned SOUND_CYCLES  = 32_500_000,
  parameter int unsigned POPUP_TIMEOUT = 130_000_000
`ifdef MOLE_SPEEDUP_EN
  ,
  parameter int unsigned SPEEDUP_STEP  = 1_000_000,
  parameter int unsigned MOLE_TIME_MIN = 16_250_000
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       player_centered,
  input  logic       mole_request,
  input  logic [2:0] request_location,
  input  logic       stomp,
  input  logic [2:0] stomp_location,
  input  logic       popup_done,
  output logic [3:0] state,
  output logic [2:0] mole_location,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       whack_pulse,
  output logic       miss_pulse
);

  typedef enum logic [3:0] {
    S_IDLE                  = 4'd0,
    S_GAME_START_DELAY      = 4'd1,
    S_GAME_ONGOING          = 4'd2,
    S_REQUEST_MOLE          = 4'd3,
    S_MOLE_COUNTDOWN        = 4'd4,
    S_MOLE_MISSED           = 4'd5,
    S_MOLE_WHACKED          = 4'd6,
    S_GAME_OVER             = 4'd8,
    S_MOLE_MISSED_SOUND     = 4'd9,
    S_MOLE_WHACKED_SOUND    = 4'd10,
    S_MOLE_ASCENDING        = 4'd13,
    S_HAPPY_MOLE_DESCENDING = 4'd14,
    S_DEAD_MOLE_DESCENDING  = 4'd15
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        arm_q, arm_d;
  logic        pending_q, pending_d;
  logic [2:0]  pend_loc_q, pend_loc_d;
  logic [2:0]  loc_q, loc_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic        start_q;

  logic        start_rise;
  logic [31:0] timer_plus1;
  logic [31:0] countdown_len;
  logic [31:0] countdown_load;

  assign start_rise  = start & ~start_q;
  assign timer_plus1 = timer_q + 32'd1;

`ifdef MOLE_SPEEDUP_EN
  // Each point shaves SPEEDUP_STEP off the countdown, clamped at the floor.
  // Compared before subtracting so the difference can never wrap.
  logic [31:0] speedup_cut;
  assign speedup_cut   = 32'(score_q) * SPEEDUP_STEP;
  assign countdown_len = (speedup_cut >= (MOLE_TIME - MOLE_TIME_MIN)) ?
                         MOLE_TIME_MIN : (MOLE_TIME - speedup_cut);
`else
  assign countdown_len = MOLE_TIME;
`endif

  // The countdown exits on the cycle the timer reads zero, so loading len-1
  // keeps the mole up for exactly countdown_len cycles.
  assign countdown_load = (countdown_len == 32'd0) ? 32'd0 : (countdown_len - 32'd1);

  // Next-state, timer, request buffer and score/lives bookkeeping
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    arm_d      = arm_q;
    pending_d  = pending_q;
    pend_loc_d = pend_loc_q;
    loc_d      = loc_q;
    score_d    = score_q;
    lives_d    = lives_q;

    // Requests arriving while a mole is busy are buffered; the newest wins.
    if (mole_request && (state_q != S_IDLE) && (state_q != S_GAME_OVER)) begin
      pending_d  = 1'b1;
      pend_loc_d = request_location;
    end

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d   = S_GAME_START_DELAY;
          timer_d   = '0;
          score_d   = '0;
          lives_d   = LIVES_INIT;
          pending_d = 1'b0;
        end
      end
      S_GAME_START_DELAY: begin
        if (!player_centered) begin
          timer_d = '0;
        end else if (timer_plus1 >= START_DELAY) begin
          state_d = S_GAME_ONGOING;
          timer_d = '0;
        end else begin
          timer_d = timer_plus1;
        end
      end
      S_GAME_ONGOING: begin
        if (lives_q == 3'd0) begin
          state_d = S_GAME_OVER;
        end else if (mole_request || pending_q) begin
          // A same-cycle request is newer than anything buffered.
          state_d   = S_REQUEST_MOLE;
          loc_d     = mole_request ? request_location : pend_loc_q;
          pending_d = 1'b0;
        end
      end
      S_REQUEST_MOLE: begin
        state_d = S_MOLE_ASCENDING;
        timer_d = '0;
        arm_d   = 1'b0;
      end
      S_MOLE_ASCENDING, S_HAPPY_MOLE_DESCENDING, S_DEAD_MOLE_DESCENDING: begin
        // popup_done only counts once it has been seen low in this state, so
        // a level left over from the previous animation cannot end this one.
        if ((arm_q && popup_done) || (timer_plus1 >= POPUP_TIMEOUT)) begin
          arm_d = 1'b0;
          if (state_q == S_MOLE_ASCENDING) begin
            state_d = S_MOLE_COUNTDOWN;
            timer_d = countdown_load;
          end else begin
            state_d = S_GAME_ONGOING;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_plus1;
          if (!popup_done) arm_d = 1'b1;
        end
      end
      S_MOLE_COUNTDOWN: begin
        // A hit on the last countdown cycle still counts as a whack.
        if (stomp && (stomp_location == loc_q)) begin
          state_d = S_MOLE_WHACKED;
        end else if (timer_q == 32'd0) begin
          state_d = S_MOLE_MISSED;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_MOLE_WHACKED: begin
        score_d = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
        state_d = S_MOLE_WHACKED_SOUND;
        timer_d = '0;
      end
      S_MOLE_MISSED: begin
        lives_d = (lives_q == 3'd0) ? lives_q : (lives_q - 3'd1);
        state_d = S_MOLE_MISSED_SOUND;
        timer_d = '0;
      end
      S_MOLE_WHACKED_SOUND, S_MOLE_MISSED_SOUND: begin
        if (timer_plus1 >= SOUND_CYCLES) begin
          state_d = (state_q == S_MOLE_WHACKED_SOUND) ? S_DEAD_MOLE_DESCENDING
                                                      : S_HAPPY_MOLE_DESCENDING;
          timer_d = '0;
          arm_d   = 1'b0;
        end else begin
          timer_d = timer_plus1;
        end
      end
      S_GAME_OVER: begin
        if (start_rise) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      arm_q      <= 1'b0;
      pending_q  <= 1'b0;
      pend_loc_q <= '0;
      loc_q      <= '0;
      score_q    <= '0;
      lives_q    <= LIVES_INIT;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      arm_q      <= arm_d;
      pending_q  <= pending_d;
      pend_loc_q <= pend_loc_d;
      loc_q      <= loc_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      start_q    <= start;
    end
  end

  assign state         = state_q;
  assign mole_location = loc_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign whack_pulse   = (state_q == S_MOLE_WHACKED);
  assign miss_pulse    = (state_q == S_MOLE_MISSED);

endmodule

// File: tb/tb_mole_game_fsm.sv
// tb_mole_game_fsm: directed bench for mole_game_fsm with a cycle model of the
// game rules (time-in-state counters) plus literal expectations per scenario.
// Honours MOLE_SPEEDUP_EN to also exercise the countdown speed-up.
module tb_mole_game_fsm;

  localparam int T_START = 4;
  localparam int T_MOLE  = 10;
  localparam int T_SND   = 3;
  localparam int T_POP   = 20;
`ifdef MOLE_SPEEDUP_EN
  localparam int T_STEP  = 1;
  localparam int T_MIN   = 4;
`endif

  localparam int ST_IDLE = 0, ST_START = 1, ST_ONG = 2, ST_REQ = 3, ST_CNT = 4,
                 ST_MIS = 5, ST_WHK = 6, ST_OVER = 8, ST_MSND = 9, ST_WSND = 10,
                 ST_ASC = 13, ST_HAPPY = 14, ST_DEAD = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       player_centered = 1'b0;
  logic       mole_request = 1'b0;
  logic [2:0] request_location = 3'd0;
  logic       stomp = 1'b0;
  logic [2:0] stomp_location = 3'd0;
  logic       popup_done = 1'b0;
  logic [3:0] state;
  logic [2:0] mole_location;
  logic [7:0] score;
  logic [2:0] lives;
  logic       whack_pulse;
  logic       miss_pulse;

  mole_game_fsm #(
    .LIVES_INIT   (3'd3),
    .START_DELAY  (T_START),
    .MOLE_TIME    (T_MOLE),
    .SOUND_CYCLES (T_SND),
    .POPUP_TIMEOUT(T_POP)
`ifdef MOLE_SPEEDUP_EN
    ,
    .SPEEDUP_STEP (T_STEP),
    .MOLE_TIME_MIN(T_MIN)
`endif
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .player_centered (player_centered),
    .mole_request    (mole_request),
    .request_location(request_location),
    .stomp           (stomp),
    .stomp_location  (stomp_location),
    .popup_done      (popup_done),
    .state           (state),
    .mole_location   (mole_location),
    .score           (score),
    .lives           (lives),
    .whack_pulse     (whack_pulse),
    .miss_pulse      (miss_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_print = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
    end
  endtask

  // ---------------- behavioural model of the game rules ----------------
  typedef struct {
    int       st;     // spec state code
    int       age;    // cycles already spent in st
    int       run;    // consecutive centred cycles
    bit       armed;  // popup_done seen low in this animation
    int       score;
    int       lives;
    bit       pend;
    bit [2:0] ploc;
    bit [2:0] loc;
    bit       sprev;
  } model_t;

  model_t m;

  function automatic model_t reset_model();
    model_t r;
    r.st = ST_IDLE; r.age = 0; r.run = 0; r.armed = 0; r.score = 0; r.lives = 3;
    r.pend = 0; r.ploc = 0; r.loc = 0; r.sprev = 0;
    return r;
  endfunction

  function automatic model_t go(input model_t n, input int s);
    model_t r = n;
    r.st = s; r.age = 0; r.armed = 0;
    return r;
  endfunction

  function automatic int cd_len(input int sc);
`ifdef MOLE_SPEEDUP_EN
    longint cut = longint'(sc) * T_STEP;
    return (cut >= T_MOLE - T_MIN) ? T_MIN : int'(T_MOLE - cut);
`else
    return (sc >= 0) ? T_MOLE : T_MOLE;
`endif
  endfunction

  function automatic model_t step(input model_t c, input logic st_i, input logic pc_i,
                                  input logic rq_i, input logic [2:0] rl_i,
                                  input logic sp_i, input logic [2:0] sl_i, input logic pd_i);
    model_t n = c;
    bit rise = st_i && !c.sprev;
    n.age = c.age + 1;
    n.sprev = st_i;
    if (rq_i && c.st != ST_IDLE && c.st != ST_OVER) begin
      n.pend = 1; n.ploc = rl_i;
    end
    case (c.st)
      ST_IDLE: if (rise) begin
        n = go(n, ST_START); n.score = 0; n.lives = 3; n.pend = 0; n.run = 0;
      end
      ST_START: begin
        n.run = pc_i ? c.run + 1 : 0;
        if (n.run >= T_START) n = go(n, ST_ONG);
      end
      ST_ONG: begin
        if (c.lives == 0) n = go(n, ST_OVER);
        else if (rq_i || c.pend) begin
          n.loc = rq_i ? rl_i : c.ploc; n.pend = 0; n = go(n, ST_REQ);
        end
      end
      ST_REQ: n = go(n, ST_ASC);
      ST_ASC, ST_HAPPY, ST_DEAD: begin
        if (!pd_i) n.armed = 1;
        if ((c.armed && pd_i) || (c.age + 1 >= T_POP))
          n = go(n, (c.st == ST_ASC) ? ST_CNT : ST_ONG);
      end
      ST_CNT: begin
        if (sp_i && sl_i == c.loc) n = go(n, ST_WHK);
        else if (c.age + 1 >= cd_len(c.score)) n = go(n, ST_MIS);
      end
      ST_WHK: begin n.score = (c.score < 255) ? c.score + 1 : 255; n = go(n, ST_WSND); end
      ST_MIS: begin n.lives = (c.lives > 0) ? c.lives - 1 : 0; n = go(n, ST_MSND); end
      ST_WSND: if (c.age + 1 >= T_SND) n = go(n, ST_DEAD);
      ST_MSND: if (c.age + 1 >= T_SND) n = go(n, ST_HAPPY);
      ST_OVER: if (rise) n = go(n, ST_IDLE);
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= reset_model();
    else m <= step(m, start, player_centered, mole_request, request_location,
                   stomp, stomp_location, popup_done);
  end

  // ---------------- per-cycle compare + DUT trace recording ----------------
  logic [63:0] seq_code = '0;   // nibble trace of DUT state changes
  int          last_st = 0;
  int          run_len = 0;
  int          last_dwell[16];
  int          whack_cnt = 0;
  int          miss_cnt = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      check("state", 64'(state), 64'(m.st));
      check("mole_location", 64'(mole_location), 64'(m.loc));
      check("score", 64'(score), 64'(m.score));
      check("lives", 64'(lives), 64'(m.lives));
      check("whack_pulse", 64'(whack_pulse), 64'(m.st == ST_WHK));
      check("miss_pulse", 64'(miss_pulse), 64'(m.st == ST_MIS));
    end
    if (int'(state) != last_st) begin
      last_dwell[last_st] = run_len;
      run_len = 1;
      last_st = int'(state);
      seq_code = (seq_code << 4) | 64'(state);
    end else begin
      run_len++;
    end
    if (whack_pulse) whack_cnt++;
    if (miss_pulse) miss_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_model(input int st, input int budget);
    int k = 0;
    while (m.st != st && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("reach_state", 64'(m.st), 64'(st));
  endtask

  task automatic pulse_req(input logic [2:0] loc);
    mole_request = 1'b1; request_location = loc;
    @(negedge clk);
    mole_request = 1'b0;
  endtask

  task automatic pulse_stomp(input logic [2:0] loc);
    stomp = 1'b1; stomp_location = loc;
    @(negedge clk);
    stomp = 1'b0;
  endtask

  task automatic ascend();
    wait_model(ST_ASC, 10);
    tick(1);
    popup_done = 1'b1;
    wait_model(ST_CNT, 10);
    popup_done = 1'b0;
  endtask

  task automatic descend(input int st);
    wait_model(st, 40);
    tick(1);
    popup_done = 1'b1;
    wait_model(ST_ONG, 10);
    popup_done = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; player_centered = 1'b1;
    wait_model(ST_ONG, 10);
    player_centered = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(1);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_lives", 64'(lives), 64'd3);
    check("rst_score", 64'(score), 64'd0);
    check("rst_loc", 64'(mole_location), 64'd0);
    check("rst_pulses", 64'({whack_pulse, miss_pulse}), 64'd0);
    $display("txn reset: state=%0d lives=%0d score=%0d", state, lives, score);

    // Start with centring interrupted after 3 cycles -> counter restarts.
    seq_code = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; player_centered = 1'b1;
    tick(3);
    player_centered = 1'b0;
    tick(1);
    player_centered = 1'b1;
    wait_model(ST_ONG, 10);
    player_centered = 1'b0;
    #1;
    check("start_seq", seq_code, 64'h12);
    check("start_dwell", 64'(last_dwell[ST_START]), 64'd8);
    $display("txn start: centred delay dwell=%0d", last_dwell[ST_START]);

    // Whack at location 5.
    tick(2);
    seq_code = '0; whack_cnt = 0;
    pulse_req(3'd5);
    ascend();
    tick(3);
    pulse_stomp(3'd5);
    descend(ST_DEAD);
    #1;
    check("whack_seq", seq_code, 64'h3D46AF2);
    check("whack_score", 64'(score), 64'd1);
    check("whack_pulse_len", 64'(whack_cnt), 64'd1);
    check("whack_sound_dwell", 64'(last_dwell[ST_WSND]), 64'd3);
    check("whack_loc", 64'(mole_location), 64'd5);
    $display("txn whack: loc=%0d score=%0d", mole_location, score);

    // Miss at location 2 with a stray non-matching stomp.
    tick(2);
    seq_code = '0; miss_cnt = 0;
    pulse_req(3'd2);
    ascend();
    tick(2);
    pulse_stomp(3'd3);
    descend(ST_HAPPY);
    #1;
    check("miss_seq", seq_code, 64'h3D459E2);
    check("miss_lives", 64'(lives), 64'd2);
    check("miss_countdown", 64'(last_dwell[ST_CNT]), 64'd10);
    check("miss_pulse_len", 64'(miss_cnt), 64'd1);
    $display("txn miss: loc=%0d lives=%0d", mole_location, lives);

    // Two buffered requests, stale popup_done, then whack on the timeout cycle.
    tick(2);
    seq_code = '0;
    pulse_req(3'd4);
    ascend();
    pulse_req(3'd1);
    pulse_req(3'd6);
    pulse_stomp(3'd4);
    wait_model(ST_WSND, 5);
    popup_done = 1'b1;
    wait_model(ST_ONG, 40);
    popup_done = 1'b0;
    #1;
    check("watchdog_dwell", 64'(last_dwell[ST_DEAD]), 64'd20);
    ascend();
    #1;
    check("buffered_loc", 64'(mole_location), 64'd6);
    tick(9);
    pulse_stomp(3'd6);
    descend(ST_DEAD);
    #1;
    check("edge_whack_seq", seq_code, 64'h3D46AF23D46AF2);
    check("edge_whack_dwell", 64'(last_dwell[ST_CNT]), 64'd10);
    check("edge_whack_score", 64'(score), 64'd3);
    $display("txn buffered+edge whack: loc=%0d score=%0d", mole_location, score);

    // Two more misses -> game over; inputs ignored there; start -> idle.
    tick(2);
    pulse_req(3'd0);
    ascend();
    descend(ST_HAPPY);
    tick(1);
    pulse_req(3'd7);
    ascend();
    descend(ST_HAPPY);
    wait_model(ST_OVER, 5);
    pulse_req(3'd7);
    pulse_stomp(3'd7);
    tick(3);
    #1;
    check("over_state", 64'(state), 64'd8);
    check("over_lives", 64'(lives), 64'd0);
    check("over_score", 64'(score), 64'd3);
    $display("txn game over: lives=%0d score=%0d", lives, score);
    @(negedge clk);
    start = 1'b1;
    wait_model(ST_IDLE, 5);
    start = 1'b0;
    #1;
    check("over_to_idle", 64'(state), 64'd0);

    // Asynchronous reset mid-game drops the buffered request.
    tick(2);
    start_game();
    pulse_req(3'd3);
    ascend();
    pulse_req(3'd5);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_state", 64'(state), 64'd0);
    check("async_rst_lives", 64'(lives), 64'd3);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    start_game();
    tick(5);
    #1;
    check("pending_lost", 64'(state), 64'd2);
    $display("txn async reset: state=%0d", state);

`ifdef MOLE_SPEEDUP_EN
    for (int i = 0; i < 255; i++) begin
      pulse_req(3'(i));
      ascend();
      pulse_stomp(3'(i));
      descend(ST_DEAD);
    end
    #1;
    check("speed_score", 64'(score), 64'd255);
    pulse_req(3'd1);
    ascend();
    descend(ST_HAPPY);
    #1;
    check("speed_min_len", 64'(last_dwell[ST_CNT]), 64'(T_MIN));
    pulse_req(3'd2);
    ascend();
    tick(T_MIN - 1);
    pulse_stomp(3'd2);
    descend(ST_DEAD);
    #1;
    check("speed_edge_len", 64'(last_dwell[ST_CNT]), 64'(T_MIN));
    check("speed_saturate", 64'(score), 64'd255);
    $display("txn speedup: score=%0d countdown=%0d", score, last_dwell[ST_CNT]);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
